// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one step per clock, with a one-cycle path for div-by-zero/overflow.
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MD_START_i,
  input  logic             MD_ABORT_i,
  input  logic [2:0]       MD_OP_i,
  input  logic [WIDTH-1:0] MD_RS1_i,
  input  logic [WIDTH-1:0] MD_RS2_i,
  output logic [WIDTH-1:0] MD_RD_o,
  output logic             MD_BUSY_o,
  output logic             MD_DONE_o,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ABS     = 3'd1,
    S_CALC    = 3'd2,
    S_FINISH  = 3'd3,
    S_SPECIAL = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: MD_START_i is accepted only in IDLE, when MD_ABORT_i is low and
  // no DONE pulse is showing; MD_DONE_o marks MD_RD_o valid for that one cycle
  // and is never high together with MD_BUSY_o.
  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, hi_q, lo_q, rd_q;
  logic             neg_q, rneg_q, done_q;
  logic [CNT_W-1:0] cnt_q;

  logic             launch, special_in, last_iter;
  logic             rs1_signed, rs2_signed, s1, s2, fits;
  logic [WIDTH-1:0] abs1, abs2, fin_res, spec_res;
  logic [WIDTH:0]   msum, rsh, rdiff;
  logic [2*WIDTH-1:0] prod, prod_c;

  assign special_in = MD_OP_i[2] && ((MD_RS2_i == '0) ||
                      (!MD_OP_i[0] && (MD_RS1_i == MIN_NEG) && (MD_RS2_i == '1)));
  assign launch     = (state_q == S_IDLE) && MD_START_i && !MD_ABORT_i && !done_q;
  assign last_iter  = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin : state_reg
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (launch) state_d = special_in ? S_SPECIAL : S_ABS;
      S_ABS:     state_d = S_CALC;
      S_CALC:    if (last_iter) state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      S_SPECIAL: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (MD_ABORT_i) state_d = S_IDLE;
  end

  always_comb begin : outputs
    MD_BUSY_o = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  assign MD_RD_o   = rd_q;
  assign MD_DONE_o = done_q;

  // Before ABS, a_q holds raw RS1 and lo_q raw RS2; signs are taken from those.
  always_comb begin : dp_comb
    rs1_signed = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    rs2_signed = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    s1    = rs1_signed && a_q[WIDTH-1];
    s2    = rs2_signed && lo_q[WIDTH-1];
    abs1  = s1 ? -a_q : a_q;
    abs2  = s2 ? -lo_q : lo_q;
    msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    rsh   = {hi_q, lo_q[WIDTH-1]};
    rdiff = rsh - {1'b0, a_q};
    fits  = !rdiff[WIDTH];
    prod  = {hi_q, lo_q};
    prod_c = neg_q ? -prod : prod;
    case (op_q)
      3'b000:                 fin_res = prod_c[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_c[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin_res = neg_q ? -lo_q : lo_q;
      default:                fin_res = rneg_q ? -hi_q : hi_q;
    endcase
    if (lo_q == '0) spec_res = op_q[1] ? a_q : '1;
    else            spec_res = op_q[1] ? '0 : a_q;
  end

  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      op_q   <= '0;
      a_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (launch) begin
          op_q  <= MD_OP_i;
          a_q   <= MD_RS1_i;
          lo_q  <= MD_RS2_i;
          hi_q  <= '0;
          cnt_q <= '0;
        end
        S_ABS: begin
          neg_q  <= s1 ^ s2;
          rneg_q <= s1;
          cnt_q  <= '0;
          // Divide keeps the divisor in a_q and shifts the dividend through lo_q.
          if (op_q[2]) begin
            a_q  <= abs2;
            lo_q <= abs1;
          end else begin
            a_q  <= abs1;
            lo_q <= abs2;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q[2]) begin
            hi_q <= fits ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], fits};
          end else begin
            hi_q <= msum[WIDTH:1];
            lo_q <= {msum[0], lo_q[WIDTH-1:1]};
          end
        end
        S_FINISH:  if (!MD_ABORT_i) rd_q <= fin_res;
        S_SPECIAL: if (!MD_ABORT_i) rd_q <= spec_res;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin : done_reg
    if (rst) done_q <= 1'b0;
    else     done_q <= !MD_ABORT_i && ((state_q == S_FINISH) || (state_q == S_SPECIAL));
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 plus a WIDTH=8 random sweep
// checked against a behavioural RV32M model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, abort32, busy32, done32;
  logic [2:0]  op32, st32;
  logic [31:0] rs1_32, rs2_32, rd32;
  logic        start8, abort8, busy8, done8;
  logic [2:0]  op8, st8;
  logic [7:0]  rs1_8, rs2_8, rd8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .MD_START_i(start32), .MD_ABORT_i(abort32), .MD_OP_i(op32),
    .MD_RS1_i(rs1_32), .MD_RS2_i(rs2_32), .MD_RD_o(rd32), .MD_BUSY_o(busy32),
    .MD_DONE_o(done32), .dbg_state(st32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .MD_START_i(start8), .MD_ABORT_i(abort8), .MD_OP_i(op8),
    .MD_RS1_i(rs1_8), .MD_RS2_i(rs2_8), .MD_RD_o(rd8), .MD_BUSY_o(busy8),
    .MD_DONE_o(done8), .dbg_state(st8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one start pulse; returns just after the start edge.
  task automatic launch32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op32 = op; rs1_32 = a; rs2_32 = b; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0; rs1_32 = ~a; rs2_32 = ~b; op32 = ~op;
  endtask

  // lat counts edges since the start edge; returns at the negedge DONE is seen.
  task automatic wait_done32(input int lat0, output logic [31:0] res, output int lat, output logic busy_ok);
    lat = lat0;
    busy_ok = 1'b1;
    res = 'x;
    while (1) begin
      @(negedge clk);
      if (done32) begin
        if (busy32) busy_ok = 1'b0;
        res = rd32;
        break;
      end
      if (!busy32) busy_ok = 1'b0;
      if (lat >= 200) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic vec32(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat;
    logic busy_ok;
    launch32(op, a, b);
    wait_done32(0, res, lat, busy_ok);
    check({tag, "_rd"}, res, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic launch8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op8 = op; rs1_8 = a; rs2_8 = b; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; rs1_8 = ~a; rs2_8 = ~b;
  endtask

  task automatic wait_done8(output logic [7:0] res, output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    res = 'x;
    while (1) begin
      @(negedge clk);
      if (done8) begin
        if (busy8) busy_ok = 1'b0;
        res = rd8;
        break;
      end
      if (!busy8) busy_ok = 1'b0;
      if (lat >= 100) break;
      @(posedge clk);
      lat++;
    end
  endtask

  function automatic logic [7:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    longint sa, sb, p, q, r;
    logic s1, s2;
    s1 = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    s2 = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    sa = s1 ? longint'($signed(a)) : longint'(a);
    sb = s2 ? longint'($signed(b)) : longint'(b);
    if (!op[2]) begin
      p = sa * sb;
      return (op == 3'd0) ? p[7:0] : p[15:8];
    end
    if (b == 8'h00) return op[1] ? a : 8'hff;
    if (!op[0] && a == 8'h80 && b == 8'hff) return op[1] ? 8'h00 : 8'h80;
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[7:0] : q[7:0];
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 6))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hff;
      3: return 8'h01;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] res, prev;
    logic [7:0]  res8, a8, b8;
    int lat;
    logic busy_ok, saw_done, bad8;

    rst = 1'b1;
    start32 = 1'b0; abort32 = 1'b0; op32 = '0; rs1_32 = '0; rs2_32 = '0;
    start8 = 1'b0; abort8 = 1'b0; op8 = '0; rs1_8 = '0; rs2_8 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_rd", rd32, 32'd0);
    check("reset_busy", {31'd0, busy32}, 32'd0);
    check("reset_done", {31'd0, done32}, 32'd0);

    vec32("mul_7x6",       3'd0, 32'd7,        32'd6,        32'd42,       34);
    vec32("mulh_m2x3",     3'd1, 32'hfffffffe, 32'd3,        32'hffffffff, 34);
    vec32("mulhu_max",     3'd3, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 34);
    vec32("mulhsu_m1x2",   3'd2, 32'hffffffff, 32'd2,        32'hffffffff, 34);
    vec32("mul_min_m1",    3'd0, 32'h80000000, 32'hffffffff, 32'h80000000, 34);
    vec32("mulh_min_m1",   3'd1, 32'h80000000, 32'hffffffff, 32'h00000000, 34);
    vec32("div_m7_2",      3'd4, 32'hfffffff9, 32'd2,        32'hfffffffd, 34);
    vec32("rem_m7_2",      3'd6, 32'hfffffff9, 32'd2,        32'hffffffff, 34);
    vec32("div_7_m2",      3'd4, 32'd7,        32'hfffffffe, 32'hfffffffd, 34);
    vec32("rem_7_m2",      3'd6, 32'd7,        32'hfffffffe, 32'd1,        34);
    vec32("divu_100_7",    3'd5, 32'd100,      32'd7,        32'd14,       34);
    vec32("remu_100_7",    3'd7, 32'd100,      32'd7,        32'd2,        34);
    vec32("divu_5_0",      3'd5, 32'd5,        32'd0,        32'hffffffff, 1);
    vec32("rem_5_0",       3'd6, 32'd5,        32'd0,        32'd5,        1);
    vec32("div_ovf",       3'd4, 32'h80000000, 32'hffffffff, 32'h80000000, 1);
    vec32("rem_ovf",       3'd6, 32'h80000000, 32'hffffffff, 32'd0,        1);

    // Abort at edge 10 of a MUL: idle after that edge, no DONE, result held.
    prev = rd32;
    launch32(3'd0, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk) abort32 = 1'b1;
    @(posedge clk);
    @(negedge clk) abort32 = 1'b0;
    check("abort_busy", {31'd0, busy32}, 32'd0);
    saw_done = 1'b0;
    repeat (40) @(negedge clk) if (done32) saw_done = 1'b1;
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_rd_held", rd32, prev);

    // START while busy must not disturb the operation in flight.
    launch32(3'd0, 32'd9, 32'd9);
    repeat (4) @(posedge clk);
    #1 op32 = 3'd5; rs1_32 = 32'd1; rs2_32 = 32'd1; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    wait_done32(5, res, lat, busy_ok);
    check("busy_start_rd", res, 32'd81);
    check("busy_start_lat", 32'(lat), 32'd34);

    // START held during the DONE cycle is dropped.
    start32 = 1'b1; op32 = 3'd5; rs1_32 = 32'd8; rs2_32 = 32'd0;
    @(posedge clk);
    #1 start32 = 1'b0;
    @(negedge clk);
    check("done_start_busy", {31'd0, busy32}, 32'd0);
    saw_done = 1'b0;
    repeat (5) @(negedge clk) if (done32) saw_done = 1'b1;
    check("done_start_no_done", {31'd0, saw_done}, 32'd0);
    check("done_start_rd", rd32, 32'd81);

    // Reset at edge 20 of a DIV clears everything, then a normal DIVU.
    launch32(3'd4, 32'd1000, 32'd7);
    repeat (19) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_rd", rd32, 32'd0);
    check("midreset_busy", {31'd0, busy32}, 32'd0);
    check("midreset_done", {31'd0, done32}, 32'd0);
    rst = 1'b0;
    vec32("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 34);

    // WIDTH=8 sweep against the behavioural model.
    bad8 = 1'b0;
    for (int op = 0; op < 8; op++) begin
      for (int i = 0; i < 100; i++) begin
        a8 = pick8();
        b8 = pick8();
        launch8(3'(op), a8, b8);
        wait_done8(res8, lat, busy_ok);
        if (!busy_ok) bad8 = 1'b1;
        check($sformatf("w8_op%0d_%h_%h", op, a8, b8), {24'd0, res8}, {24'd0, ref8(3'(op), a8, b8)});
        check($sformatf("w8_lat_op%0d_%h_%h", op, a8, b8), 32'(lat),
              (op >= 4 && (b8 == 8'h00 || (op[0] == 1'b0 && a8 == 8'h80 && b8 == 8'hff))) ? 32'd1 : 32'd10);
      end
    end
    check("w8_busy_done_exclusive", {31'd0, bad8}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
